// File: rtl/instr_mem_loadable_if.sv
// Fetch and byte-serial program-load signals of the loadable instruction memory.
// master = pipeline/loader side, slave = memory side.
interface instr_mem_loadable_if #(parameter int ADDR_WIDTH = 8);
  logic [31:0]         if_addr;
  logic                if_req;
  logic                if_stall;
  logic                if_flush;
  logic [31:0]         instr;
  logic                instr_valid;
  logic                addr_err;
  logic                ld_start;
  logic [ADDR_WIDTH:0] ld_word_count;
  logic                ld_byte_valid;
  logic [7:0]          ld_byte;
  logic                ld_busy;
  logic                ld_done;

  modport master (
    output if_addr, if_req, if_stall, if_flush,
    output ld_start, ld_word_count, ld_byte_valid, ld_byte,
    input  instr, instr_valid, addr_err, ld_busy, ld_done
  );

  modport slave (
    input  if_addr, if_req, if_stall, if_flush,
    input  ld_start, ld_word_count, ld_byte_valid, ld_byte,
    output instr, instr_valid, addr_err, ld_busy, ld_done
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Instruction memory with a 1-cycle registered fetch port (stall/flush/address error)
// and a byte-serial big-endian program-load FSM that blocks fetch while loading.
module instr_mem_loadable #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input logic                clk,
  input logic                reset,
  instr_mem_loadable_if.slave bus
);
  localparam int                  DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_WIDTH:0] cnt, wr_ptr, cnt_cap;
  logic [1:0]          byte_cnt;
  logic [23:0]         asm_r;
  logic [31:0]         instr_r;
  logic                valid_r, err_r, busy_r, done_r;
  logic [ADDR_WIDTH-1:0] idx;
  logic                err, we;

  assign idx     = bus.if_addr[ADDR_WIDTH+1:2];
  assign err     = (|bus.if_addr[1:0]) | (|bus.if_addr[31:ADDR_WIDTH+2]);
  assign we      = (state == LOAD) && bus.ld_byte_valid && (byte_cnt == 2'd3);
  assign cnt_cap = (bus.ld_word_count > DEPTH_W) ? DEPTH_W : bus.ld_word_count;

  assign bus.instr       = instr_r;
  assign bus.instr_valid = valid_r;
  assign bus.addr_err    = err_r;
  assign bus.ld_busy     = busy_r;
  assign bus.ld_done     = done_r;

  // Storage has no reset so a reset mid-load keeps already written words.
  always_ff @(posedge clk)
    if (we) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {asm_r, bus.ld_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      instr_r  <= NOP_WORD;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cnt      <= '0;
      wr_ptr   <= '0;
      byte_cnt <= '0;
      asm_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            cnt      <= cnt_cap;
            wr_ptr   <= '0;
            byte_cnt <= '0;
            // Fetch outputs go quiet for the whole LOAD/DONE window.
            instr_r  <= NOP_WORD;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            if (cnt_cap == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state  <= LOAD;
              busy_r <= 1'b1;
            end
          end else if (bus.if_flush) begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
          end else if (bus.if_stall) begin
            instr_r <= instr_r;
          end else if (bus.if_req) begin
            instr_r <= err ? NOP_WORD : mem[idx];
            valid_r <= 1'b1;
            err_r   <= err;
          end else begin
            instr_r <= NOP_WORD;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.ld_byte_valid) begin
            asm_r <= {asm_r[15:0], bus.ld_byte};
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              wr_ptr   <= wr_ptr + 1'b1;
              if (wr_ptr + 1'b1 == cnt) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed + randomized bench for instr_mem_loadable against a word-array reference model.
module tb_instr_mem_loadable;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_loadable_if #(.ADDR_WIDTH(AW)) bus();
  instr_mem_loadable #(.ADDR_WIDTH(AW), .NOP_WORD(32'h0)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] e_instr;
  logic        e_valid, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input bit busy, input bit done);
    chk({tag, ".instr"}, bus.instr, e_instr);
    chk({tag, ".valid"}, 32'(bus.instr_valid), 32'(e_valid));
    chk({tag, ".err"}, 32'(bus.addr_err), 32'(e_err));
    chk({tag, ".busy"}, 32'(bus.ld_busy), 32'(busy));
    chk({tag, ".done"}, 32'(bus.ld_done), 32'(done));
  endtask

  // One fetch-port cycle; the model follows flush > stall > req > idle.
  task automatic fetch(input logic [31:0] a, input bit req, input bit stall, input bit flush,
                       input string tag);
    bus.if_addr = a; bus.if_req = req; bus.if_stall = stall; bus.if_flush = flush;
    step();
    if (flush) begin
      e_instr = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    end else if (stall) begin
      e_instr = e_instr;
    end else if (req) begin
      e_err   = (a[1:0] != 2'b0) || (a >= 32'(DEPTH * 4));
      e_instr = e_err ? 32'h0 : mem_m[a[AW+1:2]];
      e_valid = 1'b1;
    end else begin
      e_instr = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    end
    chk_outs(tag, 1'b0, 1'b0);
  endtask

  // Loader byte; fetch inputs and ld_start are scrambled to show they are ignored.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit last);
    if (gap) begin
      bus.ld_byte_valid = 1'b0;
      bus.ld_byte = 8'($urandom);
      bus.ld_start = 1'($urandom);
      bus.ld_word_count = (AW+1)'($urandom);
      bus.if_addr = $urandom; bus.if_req = 1'($urandom);
      bus.if_stall = 1'($urandom); bus.if_flush = 1'($urandom);
      step();
      chk_outs("load_gap", 1'b1, 1'b0);
    end
    bus.ld_start = 1'b0;
    bus.ld_byte_valid = 1'b1;
    bus.ld_byte = b;
    step();
    bus.ld_byte_valid = 1'b0;
    chk_outs(last ? "load_last" : "load_byte", !last, last);
  endtask

  task automatic do_load(input logic [AW:0] wc, input logic [31:0] words[$], input bit gaps);
    int c;
    logic [31:0] wd;
    c = (int'(wc) > DEPTH) ? DEPTH : int'(wc);
    e_instr = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    bus.if_req = 1'b0; bus.if_stall = 1'b0; bus.if_flush = 1'b0;
    bus.ld_word_count = wc;
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    chk_outs("load_start", c != 0, c == 0);
    for (int w = 0; w < c; w++) begin
      wd = words[w];
      for (int b = 0; b < 4; b++)
        send_byte(wd[31-8*b -: 8], gaps && ($urandom_range(3) == 0), (w == c-1) && (b == 3));
      mem_m[w[AW-1:0]] = wd;
    end
    bus.if_req = 1'b0; bus.if_stall = 1'b0; bus.if_flush = 1'b0;
    bus.ld_start = 1'b0;
    step();
    chk_outs("load_end", 1'b0, 1'b0);
  endtask

  logic [31:0] q[$];
  logic [31:0] a;
  logic [31:0] old_w1;

  initial begin
    reset = 1'b1;
    bus.if_addr = '0; bus.if_req = 1'b0; bus.if_stall = 1'b0; bus.if_flush = 1'b0;
    bus.ld_start = 1'b0; bus.ld_word_count = '0; bus.ld_byte_valid = 1'b0; bus.ld_byte = '0;
    e_instr = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;

    // Reset state
    step(); step();
    chk_outs("reset", 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_outs("post_reset", 1'b0, 1'b0);

    // Three-word load then back-to-back fetch
    q = '{32'h20040005, 32'h00001026, 32'h0C000004};
    do_load((AW+1)'(3), q, 1'b0);
    fetch(32'h0, 1, 0, 0, "t2_f0"); chk("t2_w0", bus.instr, 32'h20040005);
    fetch(32'h4, 1, 0, 0, "t2_f4"); chk("t2_w1", bus.instr, 32'h00001026);
    fetch(32'h8, 1, 0, 0, "t2_f8"); chk("t2_w2", bus.instr, 32'h0C000004);

    // Stall holds, release delivers the new address one cycle later
    fetch(32'h4, 1, 0, 0, "t3_f4");
    for (int i = 0; i < 3; i++) begin
      fetch(32'h8, 1, 1, 0, "t3_stall");
      chk("t3_hold", bus.instr, 32'h00001026);
    end
    fetch(32'h8, 1, 0, 0, "t3_rel"); chk("t3_rel_w", bus.instr, 32'h0C000004);

    // Flush beats stall
    fetch(32'h8, 1, 1, 1, "t4_flush");
    chk("t4_valid", 32'(bus.instr_valid), 32'h0);

    // Fill the whole memory; word count above DEPTH is clamped
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
    do_load((AW+1)'(300), q, 1'b1);

    // Address errors and the top in-range word
    fetch(32'h6, 1, 0, 0, "t5_mis");   chk("t5_mis_err", 32'(bus.addr_err), 32'h1);
    fetch(32'h400, 1, 0, 0, "t5_oor"); chk("t5_oor_err", 32'(bus.addr_err), 32'h1);
    fetch(32'h3FC, 1, 0, 0, "t5_top"); chk("t5_top_err", 32'(bus.addr_err), 32'h0);

    // Random fetch traffic, a short gappy reload, more traffic
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 300; i++) begin
        case ($urandom_range(9))
          7:       a = {22'h0, 8'($urandom), 2'($urandom_range(3, 1))};
          8:       a = {22'($urandom_range(1 << 22 - 1, 1)), 8'($urandom), 2'b00};
          9:       a = $urandom;
          default: a = {22'h0, 8'($urandom), 2'b00};
        endcase
        fetch(a, $urandom_range(9) < 7, $urandom_range(9) < 2, $urandom_range(9) == 0, "rnd");
      end
      if (pass == 0) begin
        q = {};
        for (int i = 0; i < 8; i++) q.push_back($urandom);
        do_load((AW+1)'($urandom_range(8, 1)), q, 1'b1);
      end
    end

    // Reset in the middle of a load: word 0 written, word 1 untouched
    old_w1 = mem_m[1];
    q = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC};
    e_instr = 32'h0; e_valid = 1'b0; e_err = 1'b0;
    bus.if_req = 1'b0; bus.if_stall = 1'b0; bus.if_flush = 1'b0;
    bus.ld_word_count = (AW+1)'(4);
    bus.ld_start = 1'b1;
    step();
    bus.ld_start = 1'b0;
    chk_outs("t6_start", 1'b1, 1'b0);
    for (int b = 0; b < 6; b++) begin
      a = q[b / 4];
      send_byte(a[31-8*(b%4) -: 8], 1'b0, 1'b0);
    end
    mem_m[0] = 32'hAABBCCDD;
    reset = 1'b1;
    #1;
    chk_outs("t6_async_rst", 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    fetch(32'h0, 1, 0, 0, "t6_w0"); chk("t6_w0_val", bus.instr, 32'hAABBCCDD);
    fetch(32'h4, 1, 0, 0, "t6_w1"); chk("t6_w1_val", bus.instr, old_w1);

    // Zero-word load: done one cycle after start, nothing written
    q = {};
    do_load((AW+1)'(0), q, 1'b0);
    fetch(32'h0, 1, 0, 0, "t6_z0"); chk("t6_z0_val", bus.instr, 32'hAABBCCDD);
    fetch(32'h4, 1, 0, 0, "t6_z1"); chk("t6_z1_val", bus.instr, old_w1);
    fetch(32'h0, 0, 0, 0, "t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
